// File: rtl/byte_ram_ctrl.sv
// Byte-wide memory slave for the 16-bit multi-cycle core: read/write handshakes plus a loader port.
// Define RAM_WP_EN to write-protect core writes below WP_LIMIT and raise the sticky wp_err flag.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// S_IDLE    | waiting for a read pulse or a write level from the core
// S_RD_WAIT | latency countdown, then the array read (deferred if the loader owns the port)
// S_RD_SEND | ram_send high, data_read held until the core accepts
// S_WR_ACK  | ram_receive high until the core drops cpu_send
module byte_ram_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1,
  parameter logic [15:0] WP_LIMIT = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_ctrl,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_store,
  input  logic        cpu_ready,
  input  logic        cpu_send,
  input  logic        cpu_receive,
  output logic [7:0]  data_read,
  output logic        ram_send,
  output logic        ram_receive,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        busy,
  output logic        wp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_ACK
  } state_t;

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]  LAT_INIT = 3'(READ_LAT - 1);

  logic [7:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [7:0]        data_read_q, data_read_d;
  logic              ram_send_q, ram_send_d;
  logic              ram_receive_q, ram_receive_d;
  logic              busy_q, busy_d;
  logic              wp_err_q, wp_err_d;

  logic              rd_req;
  logic              wr_req;
  logic              wr_prot;
  logic              core_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] ld_addr;
  logic              unused_bits;

  assign wr_addr = data_addr[ADDR_W-1:0];
  assign ld_addr = load_addr[ADDR_W-1:0];
  assign rd_req  = cpu_ready && (mem_ctrl == 2'b10);
  assign wr_req  = cpu_send && (mem_ctrl == 2'b01) && !ram_receive_q;

`ifdef RAM_WP_EN
  // Compare the wrapped address so aliases of the program region are protected too.
  assign wr_prot = (16'(wr_addr) < WP_LIMIT);
`else
  assign wr_prot = 1'b0;
`endif

  // Upper address bits are intentionally ignored: the array wraps.
  assign unused_bits = ^{data_addr[15:ADDR_W], load_addr[15:ADDR_W], WP_LIMIT};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    data_read_d   = data_read_q;
    ram_send_d    = ram_send_q;
    ram_receive_d = ram_receive_q;
    wp_err_d      = wp_err_q;
    core_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d  = wr_addr;
          cnt_d   = LAT_INIT;
          pend_d  = 1'b0;
          state_d = S_RD_WAIT;
        end else if (wr_req) begin
          if (load_en) begin
            pend_d = 1'b1;
          end else begin
            core_we       = !wr_prot;
            wp_err_d      = wp_err_q | wr_prot;
            ram_receive_d = 1'b1;
            pend_d        = 1'b0;
            state_d       = S_WR_ACK;
          end
        end else begin
          pend_d = 1'b0;
        end
      end

      S_RD_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (load_en) begin
          pend_d = 1'b1;
        end else begin
          data_read_d = mem[addr_q];
          ram_send_d  = 1'b1;
          pend_d      = 1'b0;
          state_d     = S_RD_SEND;
        end
      end

      S_RD_SEND: begin
        if (cpu_receive) begin
          ram_send_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_WR_ACK: begin
        if (!cpu_send) begin
          ram_receive_d = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      cnt_q         <= 3'd0;
      pend_q        <= 1'b0;
      data_read_q   <= 8'h00;
      ram_send_q    <= 1'b0;
      ram_receive_q <= 1'b0;
      busy_q        <= 1'b0;
      wp_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      data_read_q   <= data_read_d;
      ram_send_q    <= ram_send_d;
      ram_receive_q <= ram_receive_d;
      busy_q        <= busy_d;
      wp_err_q      <= wp_err_d;
    end
  end

  // Contents are never reset; the loader keeps working while the block is held in reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[ld_addr] <= load_data;
    end else if (core_we && rst_n) begin
      mem[wr_addr] <= data_store;
    end
  end

  assign data_read   = data_read_q;
  assign ram_send    = ram_send_q;
  assign ram_receive = ram_receive_q;
  assign busy        = busy_q;
  assign wp_err      = wp_err_q;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Directed bench for byte_ram_ctrl (ADDR_W=10, READ_LAT=1); honours RAM_WP_EN when defined.
module tb_byte_ram_ctrl;

`ifdef RAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_ctrl;
  logic [15:0] data_addr;
  logic [7:0]  data_store;
  logic        cpu_ready;
  logic        cpu_send;
  logic        cpu_receive;
  logic [7:0]  data_read;
  logic        ram_send;
  logic        ram_receive;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;
  logic        wp_err;

  int checks   = 0;
  int failures = 0;

  byte_ram_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ctrl    (mem_ctrl),
    .data_addr   (data_addr),
    .data_store  (data_store),
    .cpu_ready   (cpu_ready),
    .cpu_send    (cpu_send),
    .cpu_receive (cpu_receive),
    .data_read   (data_read),
    .ram_send    (ram_send),
    .ram_receive (ram_receive),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy),
    .wp_err      (wp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Read with a core that accepts one cycle after ram_send rises.
  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input int exp_lat,
                         input string tag);
    int n;
    mem_ctrl = 2'b10; data_addr = a; cpu_ready = 1'b1;
    step();
    cpu_ready = 1'b0;
    n = 0;
    while (ram_send !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(exp_lat));
    chk({tag, "_data"}, 16'(data_read), 16'(exp));
    step();
    chk({tag, "_hold"}, 16'({ram_send, busy, data_read}), 16'({2'b11, exp}));
    cpu_receive = 1'b1;
    step();
    cpu_receive = 1'b0;
    chk({tag, "_done"}, 16'({ram_send, busy}), 16'h0000);
    chk({tag, "_keep"}, 16'(data_read), 16'(exp));
    mem_ctrl = 2'b00;
  endtask

  // Write holding cpu_send three cycles; data_store changes after the first edge.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input string tag);
    mem_ctrl = 2'b01; data_addr = a; data_store = d; cpu_send = 1'b1;
    step();
    chk({tag, "_ack"}, 16'({ram_receive, busy}), 16'h0003);
    data_store = ~d;
    step();
    step();
    chk({tag, "_held"}, 16'({ram_receive, busy}), 16'h0003);
    cpu_send = 1'b0;
    step();
    chk({tag, "_rel"}, 16'({ram_receive, busy}), 16'h0000);
    mem_ctrl = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; mem_ctrl = 2'b00; data_addr = 16'h0; data_store = 8'h0;
    cpu_ready = 1'b0; cpu_send = 1'b0; cpu_receive = 1'b0;
    load_en = 1'b0; load_addr = 16'h0; load_data = 8'h0;
    @(negedge clk);
    step();
    step();
    chk("rst_outs", 16'({data_read, ram_send, ram_receive, busy, wp_err}), 16'h0000);
    rst_n = 1'b1;
    step();

    load(16'h0004, 8'hA5);
    load(16'h0000, 8'h81);
    load(16'h0001, 8'h42);
    load(16'h0120, 8'h66);
    load(16'h0010, 8'h11);

    do_read(16'h0004, 8'hA5, 1, "ld_rd");

    do_read(16'h0000, 8'h81, 1, "fetch_hi");
    do_read(16'h0001, 8'h42, 1, "fetch_lo");

    do_write(16'h0210, 8'h3C, "wr210");
    do_read(16'h0210, 8'h3C, 1, "rb210");

    // Loader hits the read cycle and rewrites the same byte.
    mem_ctrl = 2'b10; data_addr = 16'h0004; cpu_ready = 1'b1;
    step();
    cpu_ready = 1'b0;
    load_en = 1'b1; load_addr = 16'h0004; load_data = 8'h5A;
    step();
    load_en = 1'b0;
    chk("coll_defer", 16'({ram_send, busy}), 16'h0001);
    step();
    chk("coll_send", 16'({ram_send, data_read}), 16'h015A);
    cpu_receive = 1'b1;
    step();
    cpu_receive = 1'b0;
    chk("coll_done", 16'({ram_send, busy}), 16'h0000);
    mem_ctrl = 2'b00;

    // Read and write requested together: read first, write once mem_ctrl selects it.
    cpu_send = 1'b1; data_store = 8'h99;
    do_read(16'h0120, 8'h66, 1, "simul_rd");
    chk("simul_nowr", 16'(ram_receive), 16'h0000);
    mem_ctrl = 2'b01;
    step();
    chk("simul_wr", 16'({ram_receive, busy}), 16'h0003);
    cpu_send = 1'b0;
    step();
    chk("simul_rel", 16'(ram_receive), 16'h0000);
    mem_ctrl = 2'b00;
    do_read(16'h0120, 8'h99, 1, "simul_rb");

    do_read(16'h0404, 8'h5A, 1, "wrap");

    // Reset while ram_send is high.
    mem_ctrl = 2'b10; data_addr = 16'h0001; cpu_ready = 1'b1;
    step();
    cpu_ready = 1'b0;
    step();
    chk("rst_pre", 16'({ram_send, data_read}), 16'h0142);
    rst_n = 1'b0;
    step();
    chk("rst_mid", 16'({ram_send, busy, data_read}), 16'h0000);
    rst_n = 1'b1; mem_ctrl = 2'b00;
    step();
    do_read(16'h0210, 8'h3C, 1, "rst_keep");

    do_write(16'h0010, 8'hFF, "wp_wr");
    do_read(16'h0010, WP ? 8'h11 : 8'hFF, 1, "wp_rb");
    chk("wp_err", 16'(wp_err), 16'(WP));
    do_write(16'h0100, 8'h44, "nwp_wr");
    do_read(16'h0100, 8'h44, 1, "nwp_rb");
    chk("wp_sticky", 16'(wp_err), 16'(WP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
